// File: rtl/spi_register_byte_fifo_if.sv
// Stream and SPI-subperipheral signals of spi_register_byte_fifo.
// The slave view belongs to the FIFO block and the master view to its environment.
interface spi_register_byte_fifo_if;
    logic       enable;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic [7:0] fifo_data;
    logic       fifo_valid;
    logic       fifo_ready;
    logic       overflow_clear;

    modport slave (
        input  enable, data_in, data_in_valid, fifo_ready, overflow_clear,
        output data_out, data_out_valid, fifo_data, fifo_valid
    );

    modport master (
        output enable, data_in, data_in_valid, fifo_ready, overflow_clear,
        input  data_out, data_out_valid, fifo_data, fifo_valid
    );
endinterface

// File: rtl/spi_register_byte_fifo.sv
// SPI subperipheral that buffers host-written bytes in a FIFO drained over valid/ready.
// It returns {overflow, count} as the status byte on the CIPO path.
module spi_register_byte_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input logic                    clock,
    input logic                    reset,
    spi_register_byte_fifo_if.slave bus
);
    localparam int unsigned PTR_WIDTH   = $clog2(DEPTH);
    localparam int unsigned COUNT_WIDTH = $clog2(DEPTH) + 1;

    logic [7:0]             mem [DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic [7:0]             data_out_q;
    logic                   data_out_valid_q;
    logic                   full, push_req, push, pop, drop;

    assign full     = (count_q == COUNT_WIDTH'(DEPTH));
    assign pop      = bus.fifo_valid && bus.fifo_ready;
    assign push_req = bus.data_in_valid && bus.enable;
    // A simultaneous pop frees a slot, so a full FIFO can still accept.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    assign bus.fifo_valid     = (count_q != '0);
    assign bus.fifo_data      = mem[rd_ptr_q];
    assign bus.data_out       = data_out_q;
    assign bus.data_out_valid = data_out_valid_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Set beats clear when a byte is dropped in the same cycle.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (bus.overflow_clear) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            overflow_q       <= 1'b0;
            data_out_q       <= 8'h00;
            data_out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            overflow_q       <= overflow_d;
            data_out_q       <= {overflow_q, 7'(count_q)};
            data_out_valid_q <= bus.enable;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.data_in;
        end
    end
endmodule

// File: tb/tb_spi_register_byte_fifo.sv
// Bench for spi_register_byte_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_spi_register_byte_fifo;
    localparam int unsigned DEPTH = 16;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    spi_register_byte_fifo_if bus();

    spi_register_byte_fifo #(.DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] q[$];
    logic       m_ovf;
    logic [7:0] m_dout;
    logic       m_dov;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("fifo_valid", 32'(bus.fifo_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("fifo_data", 32'(bus.fifo_data), 32'(q[0]));
        chk("data_out", 32'(bus.data_out), 32'(m_dout));
        chk("data_out_valid", 32'(bus.data_out_valid), 32'(m_dov));
    endtask

    // Apply one cycle of inputs, advance the model across the edge, then compare.
    task automatic step(input logic rst, input logic en, input logic dv, input logic [7:0] din,
                        input logic rdy, input logic oc);
        bit full, pop, push_req;
        reset              = rst;
        bus.enable         = en;
        bus.data_in_valid  = dv;
        bus.data_in        = din;
        bus.fifo_ready     = rdy;
        bus.overflow_clear = oc;
        @(posedge clock);
        if (rst) begin
            q.delete();
            m_ovf  = 1'b0;
            m_dout = 8'h00;
            m_dov  = 1'b0;
        end else begin
            m_dout   = {m_ovf, 7'(q.size())};
            m_dov    = en;
            full     = (q.size() == DEPTH);
            pop      = (q.size() != 0) && rdy;
            push_req = dv && en;
            if (pop) void'(q.pop_front());
            if (push_req && (!full || pop)) q.push_back(din);
            if (push_req && full && !pop) m_ovf = 1'b1;
            else if (oc) m_ovf = 1'b0;
        end
        #1;
        compare();
    endtask

    task automatic idle(input logic en);
        step(1'b0, en, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic push_byte(input logic [7:0] d);
        step(1'b0, 1'b1, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic pop_byte();
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.data_in = 8'h00;
        bus.data_in_valid = 1'b0;
        bus.fifo_ready = 1'b0;
        bus.overflow_clear = 1'b0;
        m_ovf = 1'b0;
        m_dout = 8'h00;
        m_dov = 1'b0;

        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("lit_reset_fifo_valid", 32'(bus.fifo_valid), 32'd0);
        chk("lit_reset_data_out", 32'(bus.data_out), 32'h00);
        chk("lit_reset_dov", 32'(bus.data_out_valid), 32'd0);

        // Three pushes, no pops.
        push_byte(8'hA1);
        push_byte(8'hA2);
        push_byte(8'hA3);
        idle(1'b1);
        chk("lit_three_valid", 32'(bus.fifo_valid), 32'd1);
        chk("lit_three_head", 32'(bus.fifo_data), 32'hA1);
        chk("lit_three_status", 32'(bus.data_out), 32'h03);

        // Drain them in order, then one extra ready cycle on empty.
        chk("lit_pop_a1", 32'(bus.fifo_data), 32'hA1);
        pop_byte();
        chk("lit_pop_a2", 32'(bus.fifo_data), 32'hA2);
        pop_byte();
        chk("lit_pop_a3", 32'(bus.fifo_data), 32'hA3);
        pop_byte();
        chk("lit_drained_valid", 32'(bus.fifo_valid), 32'd0);
        pop_byte();
        chk("lit_drained_status", 32'(bus.data_out), 32'h00);
        idle(1'b1);
        chk("lit_no_underflow", 32'(bus.data_out), 32'h00);

        // Overfill: 17 bytes, last one dropped.
        for (int i = 0; i <= 16; i++) push_byte(8'(i));
        idle(1'b1);
        chk("lit_full_status", 32'(bus.data_out), 32'h90);
        for (int i = 0; i < 16; i++) begin
            chk("lit_drain_order", 32'(bus.fifo_data), 32'(i));
            pop_byte();
        end
        chk("lit_after_drain_valid", 32'(bus.fifo_valid), 32'd0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        idle(1'b1);
        chk("lit_ovf_cleared", 32'(bus.data_out), 32'h00);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i));
        step(1'b0, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0);
        idle(1'b1);
        chk("lit_full_pushpop_status", 32'(bus.data_out), 32'h10);
        for (int i = 1; i < 16; i++) begin
            chk("lit_pushpop_order", 32'(bus.fifo_data), 32'(8'h20 + i));
            pop_byte();
        end
        chk("lit_new_byte_last", 32'(bus.fifo_data), 32'h55);
        pop_byte();

        // Wrap-around: 40 bytes through with concurrent draining.
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1, 1'b1, 8'($urandom), 1'($urandom_range(0, 2) != 0), 1'b0);
        end
        for (int i = 0; i < 40 && q.size() != 0; i++) pop_byte();
        chk("wrap_drained", 32'(bus.fifo_valid), 32'd0);

        // data_in_valid with enable low is ignored.
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
        chk("lit_disabled_valid", 32'(bus.fifo_valid), 32'd0);
        chk("lit_disabled_status", 32'(bus.data_out), 32'h00);
        idle(1'b1);
        chk("lit_dov_rise", 32'(bus.data_out_valid), 32'd1);
        idle(1'b0);
        chk("lit_dov_fall", 32'(bus.data_out_valid), 32'd0);
        for (int i = 0; i < 20; i++) idle(1'($urandom));

        // Reset with 5 bytes buffered and overflow set.
        for (int i = 0; i <= 16; i++) push_byte(8'(8'h40 + i));
        for (int i = 0; i < 11; i++) pop_byte();
        idle(1'b1);
        chk("lit_pre_reset_status", 32'(bus.data_out), 32'h85);
        step(1'b1, 1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
        chk("lit_post_reset_valid", 32'(bus.fifo_valid), 32'd0);
        chk("lit_post_reset_status", 32'(bus.data_out), 32'h00);
        chk("lit_post_reset_dov", 32'(bus.data_out_valid), 32'd0);

        // Randomized traffic, alternating fill-biased and drain-biased phases.
        for (int i = 0; i < 3000; i++) begin
            logic rdy;
            if ((i / 100) % 2 == 0) rdy = ($urandom_range(0, 3) == 0);
            else rdy = ($urandom_range(0, 3) != 0);
            step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 4) != 0),
                 1'($urandom_range(0, 2) != 0), 8'($urandom), rdy,
                 1'($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
